// File: rtl/mmio_pkg.sv
// MMIO responder shared definitions.
// Register offsets, bit positions and reset values.
package mmio_pkg;

    localparam logic [31:0] OFS_TXDATA  = 32'h00;
    localparam logic [31:0] OFS_STATUS  = 32'h04;
    localparam logic [31:0] OFS_CYC_LO  = 32'h08;
    localparam logic [31:0] OFS_CYC_HI  = 32'h0C;
    localparam logic [31:0] OFS_SCRATCH = 32'h10;
    localparam logic [31:0] OFS_CTRL    = 32'h14;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    localparam logic        RST_CTRL_EN = 1'b1;
    localparam logic [31:0] RST_SCRATCH = 32'h0;

    typedef enum logic [2:0] {
        REG_TXDATA,
        REG_STATUS,
        REG_CYC_LO,
        REG_CYC_HI,
        REG_SCRATCH,
        REG_CTRL,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_reg(input logic [31:0] ofs);
        case (ofs)
            OFS_TXDATA:  return REG_TXDATA;
            OFS_STATUS:  return REG_STATUS;
            OFS_CYC_LO:  return REG_CYC_LO;
            OFS_CYC_HI:  return REG_CYC_HI;
            OFS_SCRATCH: return REG_SCRATCH;
            OFS_CTRL:    return REG_CTRL;
            default:     return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-2 depth.
// Push while full succeeds only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage array, contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder beside DMEM: TX FIFO, cycle counter,
// scratch and control registers with 1-cycle reads.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          WIN_BITS   = 12,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MemWrite_EN,
    input  logic [31:0] MemAddr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        rd_hit,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          hit;
    logic [31:0]   ofs;
    reg_sel_e      sel;
    logic          we;
    logic          push_req;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          ovf;
    logic          ovf_clr;
    logic          ctrl_wr;
    logic          cyc_clr;
    logic          cyc_en;
    logic [63:0]   cyc;
    logic [31:0]   scratch;
    logic [31:0]   rdata;

    assign hit      = (MemAddr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign ofs      = 32'(MemAddr[WIN_BITS-1:0]) & ~32'h3;
    assign sel      = decode_reg(ofs);
    assign we       = hit & (|MemWrite_EN);
    assign push_req = we & (sel == REG_TXDATA) & MemWrite_EN[0];
    assign pop      = tx_valid & tx_ready;
    assign ovf_clr  = we & (sel == REG_STATUS) & MemWrite_EN[0]
                    & WriteData[ST_OVF];
    assign ctrl_wr  = we & (sel == REG_CTRL) & MemWrite_EN[0];
    assign cyc_clr  = ctrl_wr & WriteData[CTRL_CLR];
    assign tx_valid = ~fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (WriteData[7:0]),
        .pop   (pop),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Read mux from current (pre-store) register state.
    always_comb begin
        rdata = '0;
        if (hit) begin
            unique case (sel)
                REG_STATUS: begin
                    rdata = 32'(fifo_count) << ST_CNT_LSB;
                    rdata[ST_OVF]   = ovf;
                    rdata[ST_EMPTY] = fifo_empty;
                    rdata[ST_FULL]  = fifo_full;
                end
                REG_CYC_LO:  rdata = cyc[31:0];
                REG_CYC_HI:  rdata = cyc[63:32];
                REG_SCRATCH: rdata = scratch;
                REG_CTRL:    rdata[CTRL_EN] = cyc_en;
                default:     rdata = '0;
            endcase
        end
    end

    // Registered read port matching DMEM latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            ReadData <= '0;
            rd_hit   <= 1'b0;
        end else begin
            ReadData <= rdata;
            rd_hit   <= hit;
        end
    end

    // Sticky overflow, a new drop wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (push_req & fifo_full & ~pop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // Scratch register with byte-lane stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            scratch <= RST_SCRATCH;
        end else if (we & (sel == REG_SCRATCH)) begin
            for (int b = 0; b < 4; b++) begin
                if (MemWrite_EN[b]) scratch[b*8 +: 8] <= WriteData[b*8 +: 8];
            end
        end
    end

    // CTRL and cycle counter; a CLR write is a pure command
    // that leaves EN untouched so the count restarts at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_en <= RST_CTRL_EN;
            cyc    <= '0;
        end else begin
            if (ctrl_wr & ~WriteData[CTRL_CLR]) cyc_en <= WriteData[CTRL_EN];
            if (cyc_clr)     cyc <= '0;
            else if (cyc_en) cyc <= cyc + 64'd1;
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder.
// Hand-computed expectations for each register and FIFO case.
module tb_mmio_responder;

    logic        clk;
    logic        reset;
    logic [3:0]  MemWrite_EN;
    logic [31:0] MemAddr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        rd_hit;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_tests;
    int n_fail;

    localparam logic [31:0] A_TX   = 32'h1000_0000;
    localparam logic [31:0] A_ST   = 32'h1000_0004;
    localparam logic [31:0] A_LO   = 32'h1000_0008;
    localparam logic [31:0] A_HI   = 32'h1000_000C;
    localparam logic [31:0] A_SCR  = 32'h1000_0010;
    localparam logic [31:0] A_CTRL = 32'h1000_0014;

    mmio_responder dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite_EN (MemWrite_EN),
        .MemAddr     (MemAddr),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .rd_hit      (rd_hit),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        MemAddr     = a;
        WriteData   = d;
        MemWrite_EN = be;
        tick();
        MemWrite_EN = 4'h0;
        MemAddr     = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d,
                      output logic h);
        MemAddr     = a;
        MemWrite_EN = 4'h0;
        tick();
        d = ReadData;
        h = rd_hit;
        MemAddr = 32'h0;
    endtask

    logic [31:0] d;
    logic        h;

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        MemWrite_EN = 4'h0;
        MemAddr     = 32'h0;
        WriteData   = 32'h0;
        tx_ready    = 1'b0;
        tick();
        tick();
        chk("rst_rdata", ReadData, 32'h0);
        chk("rst_rdhit", 32'(rd_hit), 32'h0);
        chk("rst_txvalid", 32'(tx_valid), 32'h0);
        chk("rst_txdata", 32'(tx_data), 32'h0);
        reset = 1'b0;

        // 1: idle status and control reset values
        rd(A_ST, d, h);
        chk("t1_status", d, 32'h0000_0002);
        chk("t1_hit", 32'(h), 32'h1);
        chk("t1_txvalid", 32'(tx_valid), 32'h0);
        rd(A_CTRL, d, h);
        chk("t1_ctrl", d, 32'h1);
        rd(A_SCR, d, h);
        chk("t1_scratch", d, 32'h0);

        // 2: two bytes through with consumer ready
        tx_ready = 1'b1;
        wr(A_TX, 32'h41, 4'h1);
        chk("t2_v0", 32'(tx_valid), 32'h1);
        chk("t2_d0", 32'(tx_data), 32'h41);
        wr(A_TX, 32'h42, 4'h1);
        chk("t2_v1", 32'(tx_valid), 32'h1);
        chk("t2_d1", 32'(tx_data), 32'h42);
        tick();
        chk("t2_empty", 32'(tx_valid), 32'h0);

        // 3: overfill by one, then W1C overflow
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) wr(A_TX, 32'h10 + i, 4'h1);
        rd(A_ST, d, h);
        chk("t3_status_ovf", d, 32'h0000_1005);
        chk("t3_head", 32'(tx_data), 32'h10);
        wr(A_TX, 32'h99, 4'h2);
        rd(A_ST, d, h);
        chk("t3_lane1_nopush", d, 32'h0000_1005);
        wr(A_ST, 32'h4, 4'h1);
        rd(A_ST, d, h);
        chk("t3_status_w1c", d, 32'h0000_1001);

        // 4: push into full FIFO alongside a pop
        tx_ready = 1'b1;
        wr(A_TX, 32'hAA, 4'h1);
        tx_ready = 1'b0;
        rd(A_ST, d, h);
        chk("t4_status", d, 32'h0000_1001);
        chk("t4_head", 32'(tx_data), 32'h11);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t4_drain", 32'(tx_data), (i < 15) ? 32'h11 + i : 32'hAA);
            tick();
        end
        chk("t4_drained", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // reset while FIFO holds data
        for (int i = 0; i < 3; i++) wr(A_TX, 32'h60 + i, 4'h1);
        chk("rm_valid_pre", 32'(tx_valid), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rm_valid", 32'(tx_valid), 32'h0);
        rd(A_ST, d, h);
        chk("rm_status", d, 32'h0000_0002);

        // 5: counter clear, run, freeze
        wr(A_CTRL, 32'h2, 4'h1);
        for (int i = 0; i < 4; i++) begin
            rd(A_LO, d, h);
            chk("t5_run", d, 32'(i));
        end
        wr(A_CTRL, 32'h0, 4'h1);
        for (int i = 0; i < 10; i++) begin
            rd(A_LO, d, h);
            chk("t5_frozen", d, 32'd5);
        end
        rd(A_HI, d, h);
        chk("t5_hi", d, 32'h0);
        rd(A_CTRL, d, h);
        chk("t5_ctrl", d, 32'h0);

        // 6: scratch lanes, window miss, unmapped offset
        wr(A_SCR, 32'hFFFF_FFFF, 4'hF);
        wr(A_SCR, 32'h0000_1200, 4'b0010);
        rd(A_SCR, d, h);
        chk("t6_scratch", d, 32'hFFFF_12FF);
        wr(32'h2000_0010, 32'h0, 4'hF);
        rd(A_SCR, d, h);
        chk("t6_miss_nowr", d, 32'hFFFF_12FF);
        rd(32'h2000_0010, d, h);
        chk("t6_miss_hit", 32'(h), 32'h0);
        chk("t6_miss_data", d, 32'h0);
        wr(32'h1000_0020, 32'h1234, 4'hF);
        rd(32'h1000_0020, d, h);
        chk("t6_unmap_hit", 32'(h), 32'h1);
        chk("t6_unmap_data", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
